// File: rtl/min_n_pipe.sv
// rtl/min_n_pipe.sv - pipelined N-pixel window minimum with per-frame maximum tracker
// Optional argmin output min_idx is built when MIN_N_PIPE_ARGMIN_EN is defined.
module min_n_pipe #(
    parameter int DATA_W = 8,
    parameter int N      = 9
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                Enable,
    input  logic                in_valid,
    input  logic [N*DATA_W-1:0] pixels_in,
    input  logic                in_last,
    output logic                out_valid,
    output logic [DATA_W-1:0]   dataout,
    output logic                out_last,
    output logic [DATA_W-1:0]   frame_max,
    output logic                frame_max_valid
`ifdef MIN_N_PIPE_ARGMIN_EN
    ,
    output logic [$clog2(N)-1:0] min_idx
`endif
);
    localparam int L = $clog2(N);

    typedef enum logic {IDLE, ACCUM} state_t;

    // Element count entering stage s of the comparator tree.
    function automatic int stage_cnt(input int s);
        return (N + (1 << s) - 1) >> s;
    endfunction

    function automatic int clamp(input int k);
        return (k < N) ? k : N - 1;
    endfunction

    logic [DATA_W-1:0] src_d  [0:L-1][0:N-1];
    logic [DATA_W-1:0] pipe_d [0:L-1][0:N-1];
    logic [L-1:0]      v_sr;
    logic [L-1:0]      l_sr;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_d[0][i] = pixels_in[i*DATA_W +: DATA_W];
        end
        for (int s = 1; s < L; s++) begin
            for (int i = 0; i < N; i++) begin
                src_d[s][i] = pipe_d[s-1][i];
            end
        end
    end

    // The right-hand element of a pair wins only when strictly smaller, so ties keep the lower index.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int s = 0; s < L; s++) begin
                for (int i = 0; i < N; i++) begin
                    pipe_d[s][i] <= '0;
                end
            end
            v_sr <= '0;
            l_sr <= '0;
        end else if (Enable) begin
            for (int s = 0; s < L; s++) begin
                for (int i = 0; i < N; i++) begin
                    if (2*i + 1 < stage_cnt(s)) begin
                        pipe_d[s][i] <= (src_d[s][clamp(2*i+1)] < src_d[s][clamp(2*i)]) ?
                                        src_d[s][clamp(2*i+1)] : src_d[s][clamp(2*i)];
                    end else if (2*i < stage_cnt(s)) begin
                        pipe_d[s][i] <= src_d[s][clamp(2*i)];
                    end else begin
                        pipe_d[s][i] <= '0;
                    end
                end
            end
            v_sr[0] <= in_valid;
            l_sr[0] <= in_valid & in_last;
            for (int s = 1; s < L; s++) begin
                v_sr[s] <= v_sr[s-1];
                l_sr[s] <= l_sr[s-1];
            end
        end
    end

`ifdef MIN_N_PIPE_ARGMIN_EN
    logic [L-1:0] src_i  [0:L-1][0:N-1];
    logic [L-1:0] pipe_i [0:L-1][0:N-1];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            src_i[0][i] = L'(i);
        end
        for (int s = 1; s < L; s++) begin
            for (int i = 0; i < N; i++) begin
                src_i[s][i] = pipe_i[s-1][i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int s = 0; s < L; s++) begin
                for (int i = 0; i < N; i++) begin
                    pipe_i[s][i] <= '0;
                end
            end
        end else if (Enable) begin
            for (int s = 0; s < L; s++) begin
                for (int i = 0; i < N; i++) begin
                    if (2*i + 1 < stage_cnt(s)) begin
                        pipe_i[s][i] <= (src_d[s][clamp(2*i+1)] < src_d[s][clamp(2*i)]) ?
                                        src_i[s][clamp(2*i+1)] : src_i[s][clamp(2*i)];
                    end else if (2*i < stage_cnt(s)) begin
                        pipe_i[s][i] <= src_i[s][clamp(2*i)];
                    end else begin
                        pipe_i[s][i] <= '0;
                    end
                end
            end
        end
    end

    assign min_idx = pipe_i[L-1][0];
`else
    // Index tracking is not built in the default configuration.
`endif

    assign out_valid = Enable & v_sr[L-1];
    assign dataout   = pipe_d[L-1][0];
    assign out_last  = l_sr[L-1];

    state_t            state, state_next;
    logic [DATA_W-1:0] run_max, run_next;
    logic [DATA_W-1:0] fmax_q, fmax_next;
    logic [DATA_W-1:0] cand;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            run_max <= '0;
            fmax_q  <= '0;
        end else if (Enable) begin
            state   <= state_next;
            run_max <= run_next;
            fmax_q  <= fmax_next;
        end
    end

    // The closing beat reports its frame in the same cycle, so frame_max bypasses the register then.
    always_comb begin
        state_next      = state;
        run_next        = run_max;
        fmax_next       = fmax_q;
        cand            = (state == ACCUM && run_max > dataout) ? run_max : dataout;
        frame_max_valid = out_valid & out_last;
        frame_max       = frame_max_valid ? cand : fmax_q;
        if (out_valid) begin
            run_next = cand;
            if (out_last) begin
                state_next = IDLE;
                fmax_next  = cand;
            end else begin
                state_next = ACCUM;
            end
        end
    end
endmodule

// File: tb/tb_min_n_pipe.sv
// tb/tb_min_n_pipe.sv - self-checking bench for min_n_pipe (N=9 main instance, N=5 odd-width instance)
module tb_min_n_pipe;
    localparam int L9 = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, en;
    logic        valid9, last9, valid5, last5;
    logic [71:0] pix9;
    logic [39:0] pix5;
    logic        ov9, ol9, fmv9, ov5, ol5, fmv5;
    logic [7:0]  do9, fm9, do5, fm5;
`ifdef MIN_N_PIPE_ARGMIN_EN
    logic [3:0]  idx9;
    logic [2:0]  idx5;
`endif

    min_n_pipe #(.DATA_W(8), .N(9)) dut9 (
        .clock(clock), .reset_n(reset_n), .Enable(en), .in_valid(valid9),
        .pixels_in(pix9), .in_last(last9), .out_valid(ov9), .dataout(do9),
        .out_last(ol9), .frame_max(fm9), .frame_max_valid(fmv9)
`ifdef MIN_N_PIPE_ARGMIN_EN
        , .min_idx(idx9)
`endif
    );

    min_n_pipe #(.DATA_W(8), .N(5)) dut5 (
        .clock(clock), .reset_n(reset_n), .Enable(en), .in_valid(valid5),
        .pixels_in(pix5), .in_last(last5), .out_valid(ov5), .dataout(do5),
        .out_last(ol5), .frame_max(fm5), .frame_max_valid(fmv5)
`ifdef MIN_N_PIPE_ARGMIN_EN
        , .min_idx(idx5)
`endif
    );

    typedef struct {
        logic [7:0] mn;
        int         idx;
        bit         last;
        int         due;
    } exp_t;

    typedef struct {
        logic [71:0] pix;
        bit          last;
        logic [7:0]  mn;
        int          idx;
        int          gap;
    } vec_t;

    exp_t       q[$];
    int         ecnt;
    logic [7:0] acc;
    bit         acc_any;
    logic [7:0] fmax_hold;
    int         n_pass, n_chk;
    vec_t       tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [71:0] win(input logic [7:0] bg, input int pos, input logic [7:0] v);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = (k == pos) ? v : bg;
        return w;
    endfunction

    task automatic ref_min(input logic [71:0] p, output logic [7:0] mn, output int idx);
        mn  = p[7:0];
        idx = 0;
        for (int k = 1; k < 9; k++) begin
            if (p[k*8 +: 8] < mn) begin
                mn  = p[k*8 +: 8];
                idx = k;
            end
        end
    endtask

    // One clock cycle: drive, compare the outputs against the scoreboard, then advance the model at the edge.
    task automatic cycle(input bit v, input logic [71:0] p, input bit l, input bit e, input bit r,
                         input logic [7:0] emin, input int eidx);
        exp_t       h;
        bit         exp_ov;
        logic [7:0] c;
        valid9 = v; pix9 = p; last9 = l; en = e; reset_n = r;
        #1;
        exp_ov = e && q.size() > 0 && q[0].due == ecnt;
        check("out_valid", ov9, exp_ov);
        if (exp_ov) begin
            h = q.pop_front();
            check("dataout", do9, h.mn);
            check("out_last", ol9, h.last);
`ifdef MIN_N_PIPE_ARGMIN_EN
            check("min_idx", idx9, h.idx);
`endif
            c = (acc_any && acc > h.mn) ? acc : h.mn;
            if (h.last) begin
                check("frame_max_valid", fmv9, 1);
                check("frame_max", fm9, c);
                fmax_hold = c;
                acc_any   = 0;
            end else begin
                check("frame_max_valid", fmv9, 0);
                check("frame_max hold", fm9, fmax_hold);
                acc     = c;
                acc_any = 1;
            end
        end else begin
            check("frame_max_valid", fmv9, 0);
            check("frame_max hold", fm9, fmax_hold);
        end
        @(posedge clock);
        if (!r) begin
            q.delete();
            acc_any   = 0;
            fmax_hold = 0;
        end else if (e) begin
            ecnt++;
            if (v) q.push_back('{mn: emin, idx: eidx, last: l, due: ecnt + L9 - 1});
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, '0, 0, 1, 1, 8'h00, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " out_valid"}, ov9, 0);
        check({tag, " dataout"}, do9, 0);
        check({tag, " out_last"}, ol9, 0);
        check({tag, " frame_max"}, fm9, 0);
        check({tag, " frame_max_valid"}, fmv9, 0);
        check({tag, " n5 out_valid"}, ov5, 0);
        check({tag, " n5 dataout"}, do5, 0);
        check({tag, " n5 frame_max"}, fm5, 0);
    endtask

    initial begin
        logic [71:0] rp;
        logic [7:0]  rmn;
        int          ridx;
        bit          narrow;

        n_pass = 0; n_chk = 0; ecnt = 0; acc = 0; acc_any = 0; fmax_hold = 0;
        valid5 = 0; last5 = 0; pix5 = '0;
        valid9 = 0; last9 = 0; pix9 = '0; en = 1; reset_n = 0;

        tbl[0] = '{{8'h41,8'h8C,8'h33,8'h01,8'h99,8'hF0,8'h0F,8'hAA,8'h55}, 1, 8'h01, 5, 6};
        tbl[1] = '{{8'h20,8'h10,8'h20,8'h20,8'h20,8'h10,8'h20,8'h20,8'h20}, 1, 8'h10, 3, 6};
        tbl[2] = '{win(8'hFF, 1, 8'h05), 0, 8'h05, 1, 0};
        tbl[3] = '{win(8'h80, 2, 8'h40), 0, 8'h40, 2, 0};
        tbl[4] = '{win(8'h90, 6, 8'h12), 0, 8'h12, 6, 0};
        tbl[5] = '{win(8'hC0, 8, 8'h40), 0, 8'h40, 8, 0};
        tbl[6] = '{win(8'h77, 0, 8'h03), 1, 8'h03, 0, 6};
        tbl[7] = '{win(8'hFF, 0, 8'hFF), 1, 8'hFF, 0, 6};
        tbl[8] = '{win(8'h01, 8, 8'h00), 1, 8'h00, 8, 6};

        // Reset asserted with Enable high must still clear everything.
        cycle(0, '0, 0, 1, 0, 8'h00, 0);
        cycle(0, '0, 0, 1, 0, 8'h00, 0);
        check_zero("reset");

        for (int t = 0; t < 9; t++) begin
            cycle(1, tbl[t].pix, tbl[t].last, 1, 1, tbl[t].mn, tbl[t].idx);
            idle(tbl[t].gap);
            if (t == 0) check("basic frame_max", fm9, 8'h01);
            if (t == 6) check("stream frame_max", fm9, 8'h40);
        end

        // Stall for three cycles mid-stream; windows offered while stalled are not accepted.
        cycle(1, win(8'hA0, 3, 8'h30), 0, 1, 1, 8'h30, 3);
        cycle(1, win(8'hA0, 4, 8'h31), 0, 1, 1, 8'h31, 4);
        cycle(1, win(8'hA0, 5, 8'h07), 0, 1, 1, 8'h07, 5);
        repeat (3) cycle(1, win(8'h00, 0, 8'h00), 1, 0, 1, 8'h00, 0);
        cycle(1, win(8'hA0, 6, 8'h22), 0, 1, 1, 8'h22, 6);
        cycle(1, win(8'hA0, 7, 8'h10), 1, 1, 1, 8'h10, 7);
        idle(7);
        check("stall frame_max", fm9, 8'h31);

        // Reset after two of four windows discards the partial frame.
        cycle(1, win(8'hF0, 0, 8'h50), 0, 1, 1, 8'h50, 0);
        cycle(1, win(8'hF0, 1, 8'h60), 0, 1, 1, 8'h60, 1);
        idle(1);
        cycle(0, '0, 0, 1, 0, 8'h00, 0);
        check_zero("midreset");
        cycle(1, win(8'hF0, 0, 8'h44), 0, 1, 1, 8'h44, 0);
        cycle(1, win(8'hF0, 2, 8'h11), 0, 1, 1, 8'h11, 2);
        cycle(1, win(8'hF0, 4, 8'h66), 0, 1, 1, 8'h66, 4);
        cycle(1, win(8'hF0, 8, 8'h22), 1, 1, 1, 8'h22, 8);
        idle(6);
        check("after reset frame_max", fm9, 8'h66);

        // Odd width N=5: three-stage latency, minimum in the unpaired last pixel.
        valid5 = 1; last5 = 1;
        pix5   = {8'h00, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
        idle(1);
        valid5 = 0; last5 = 0;
        for (int j = 1; j <= 3; j++) begin
            check("n5 out_valid", ov5, (j == 3));
            if (j == 3) begin
                check("n5 dataout", do5, 8'h00);
                check("n5 out_last", ol5, 1);
                check("n5 frame_max_valid", fmv5, 1);
                check("n5 frame_max", fm5, 8'h00);
`ifdef MIN_N_PIPE_ARGMIN_EN
                check("n5 min_idx", idx5, 4);
`endif
            end
            #1;
            idle(1);
        end

        // Randomized traffic with stalls, frame ends and rare resets against the scoreboard.
        for (int k = 0; k < 400; k++) begin
            narrow = ($urandom_range(0, 1) == 1);
            for (int b = 0; b < 9; b++)
                rp[b*8 +: 8] = narrow ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            ref_min(rp, rmn, ridx);
            cycle($urandom_range(0, 3) != 0, rp, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 99) != 0, rmn, ridx);
        end
        idle(8);
        check("scoreboard drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/min_n_pipe.md
MIN_N_PIPE -- requirements
Module: min_n_pipe

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter N, default 9, pixels per window; legal range 2..64.
REQ-003 Port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1  reset, synchronous and active-low.
REQ-005 Port Enable  input  1  pipeline advance; low freezes all state.
REQ-006 Port in_valid  input  1  pixels_in and in_last are valid this cycle.
REQ-007 Port pixels_in  input  N*DATA_W  window pixels; pixel k is at bits [k*DATA_W +: DATA_W].
REQ-008 Port in_last  input  1  marks the last window of a frame; qualified by in_valid.
REQ-009 Port out_valid  output  1  dataout is valid this cycle.
REQ-010 Port dataout  output  DATA_W  unsigned minimum of the window.
REQ-011 Port out_last  output  1  in_last, delayed with its window.
REQ-012 Port frame_max  output  DATA_W  maximum dataout over the last completed frame.
REQ-013 Port frame_max_valid  output  1  one-cycle pulse when frame_max updates.

Function
REQ-014 Window minimum: binary comparator tree of L = ceil(log2 N) registered stages.
REQ-015 Latency: exactly L enabled cycles from in_valid to out_valid; no bubbles when Enable stays high.
REQ-016 Comparisons: unsigned, DATA_W bits; no widening.
REQ-017 Equal values: the lower pixel index wins.
REQ-018 Odd element count at a stage: the unpaired element passes through a register unchanged.
REQ-019 Valid and last bits: shift through an L-deep register chain in step with the data.
REQ-020 Enable low: every register holds its value, including the tracker state.
REQ-021 Enable low: out_valid and frame_max_valid read 0.
REQ-022 Frame tracker states: IDLE and ACCUM.
REQ-023 IDLE, output beat arrives: running max is loaded with dataout; go to ACCUM.
REQ-024 ACCUM, output beat arrives: running max is updated to max(running max, dataout).
REQ-025 Beat with out_last, in either state: frame_max is set to the final running max, including the current beat; frame_max_valid pulses; go to IDLE.
REQ-026 One-window frame (out_last on the first beat): frame_max equals that beat's dataout.
REQ-027 frame_max holds its value between updates.
REQ-028 Back-to-back frames: the beat after out_last starts the next frame with no idle cycle.

Reset
REQ-029 With reset_n low at a rising clock edge, all of the following clear to 0: pipeline data, valid and last registers; tracker state (to IDLE); running max; frame_max.
REQ-030 Reset overrides Enable.
REQ-031 Reset mid-frame: the partial frame is discarded and no frame_max_valid is issued for it.
REQ-032 First output after reset: out_valid first rises no earlier than L cycles after the first accepted in_valid.

Configuration
REQ-033 Macro MIN_N_PIPE_ARGMIN_EN.
REQ-034 Macro defined: an extra output port min_idx, width ceil(log2 N), gives the index of the winning pixel.
REQ-035 min_idx is aligned with dataout, follows the tie rule in REQ-017, and resets to 0.
REQ-036 Macro undefined: min_idx is absent and there is no index logic; all other behaviour is identical.

Verification
REQ-037 Basic 9-pixel window: N=9, DATA_W=8, pixels 0x55,0xAA,0x0F,0xF0,0x99,0x01,0x33,0x8C,0x41 with in_valid and in_last
-> after exactly 4 cycles: dataout=0x01, out_last=1, frame_max=0x01 with a pulse, min_idx=5.
REQ-038 Tie: all pixels 0x20 except indices 3 and 7 = 0x10
-> dataout=0x10, min_idx=3.
REQ-039 Streaming frame: 5 consecutive windows with minima 0x05,0x40,0x12,0x40,0x03, the last one flagged
-> dataout sequence matches on consecutive cycles; frame_max=0x40, one pulse.
REQ-040 Stall: Enable low for 3 cycles mid-stream
-> outputs frozen, out_valid=0 while stalled, no data lost or duplicated, total latency 4+3.
REQ-041 Reset mid-frame: reset_n low for 1 cycle after 2 of 4 windows
-> all outputs 0, no frame_max_valid; the next full frame reports correctly.
REQ-042 Odd width: N=5 (L=3), pixels 0xFF,0xFE,0xFD,0xFC,0x00
-> dataout=0x00 after 3 cycles.
